// File: rtl/sub16_pipe.sv
//============================================================================
// Module  : sub16_pipe
// Purpose : Two-stage pipelined subtractor, DIFF = A - B - BIN.
//           Stage 1 computes the low LO_W bits and registers the internal
//           borrow together with the high operand slices. Stage 2 finishes
//           the high slice and registers DIFF and the flags. Valid/ready
//           handshake on both sides, 1 op/cycle, 2-cycle latency.
// Ports   : clk, rst_n (async, active-low)
//           in_valid / in_ready / A / B / BIN         - operand side
//           out_valid / out_ready / DIFF / BOUT / OVF / ZERO - result side
// Config  : define SUB16_SAT_EN to saturate DIFF on signed overflow
//           (OVF and BOUT still report the raw result).
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module sub16_pipe #(
  parameter int WIDTH = 16,
  parameter int LO_W  = WIDTH / 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIN,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] DIFF,
  output logic             BOUT,
  output logic             OVF,
  output logic             ZERO
);

  localparam int HI_W = WIDTH - LO_W;

  // Stage-1 registers
  logic            r_s1_valid;
  logic [LO_W-1:0] r_lo_diff;
  logic            r_borrow_mid;
  logic [HI_W-1:0] r_a_hi;
  logic [HI_W-1:0] r_b_hi;

  // Handshake
  logic w_adv1;
  logic w_adv2;
  logic w_accept;

  // Arithmetic
  logic [LO_W:0]      w_lo_sum;
  logic [HI_W:0]      w_hi_sum;
  logic [WIDTH-1:0]   w_raw_diff;
  logic [WIDTH-1:0]   w_diff;
  logic               w_ovf;
  logic               w_bout;

  // Stage 2 may move when its output slot is empty or being drained;
  // stage 1 may move when it is empty or stage 2 moves. No skid buffer,
  // so in_ready is combinational from out_ready.
  assign w_adv2   = ~out_valid | out_ready;
  assign w_adv1   = ~r_s1_valid | w_adv2;
  assign in_ready = w_adv1;
  assign w_accept = in_valid & w_adv1;

  // Subtraction as A + ~B + ~BIN; the carry out of the low slice is the
  // inverse of the borrow passed to the high slice.
  assign w_lo_sum = {1'b0, A[LO_W-1:0]} + {1'b0, ~B[LO_W-1:0]}
                  + {{LO_W{1'b0}}, ~BIN};

  assign w_hi_sum = {1'b0, r_a_hi} + {1'b0, ~r_b_hi}
                  + {{HI_W{1'b0}}, ~r_borrow_mid};

  assign w_raw_diff = {w_hi_sum[HI_W-1:0], r_lo_diff};
  assign w_bout     = ~w_hi_sum[HI_W];
  assign w_ovf      = (r_a_hi[HI_W-1] ^ r_b_hi[HI_W-1])
                    & (r_a_hi[HI_W-1] ^ w_raw_diff[WIDTH-1]);

`ifdef SUB16_SAT_EN
  // Overflow means the true result left the signed range in the direction
  // of A's sign, so clamp towards that end.
  always_comb begin
    w_diff = w_raw_diff;
    if (w_ovf) begin
      w_diff = r_a_hi[HI_W-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                              : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign w_diff = w_raw_diff;
`endif

  // Stage 1: low slice
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_lo_diff    <= '0;
      r_borrow_mid <= 1'b0;
      r_a_hi       <= '0;
      r_b_hi       <= '0;
    end else begin
      if (w_adv1) begin
        r_s1_valid <= in_valid;
      end
      if (w_accept) begin
        r_lo_diff    <= w_lo_sum[LO_W-1:0];
        r_borrow_mid <= ~w_lo_sum[LO_W];
        r_a_hi       <= A[WIDTH-1:LO_W];
        r_b_hi       <= B[WIDTH-1:LO_W];
      end
    end
  end

  // Stage 2: high slice, flags and output register. Data is only reloaded
  // when a real op moves in, so a bubble leaves the last result untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      DIFF      <= '0;
      BOUT      <= 1'b0;
      OVF       <= 1'b0;
      ZERO      <= 1'b0;
    end else if (w_adv2) begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        DIFF <= w_diff;
        BOUT <= w_bout;
        OVF  <= w_ovf;
        ZERO <= (w_diff == '0);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sub16_pipe.sv
//============================================================================
// Module  : tb_sub16_pipe
// Purpose : Self-checking bench for sub16_pipe. Directed corner cases,
//           back-to-back random ops, stall/backpressure, random handshake
//           mix and reset with ops in flight, compared against an
//           arithmetic reference model held in a queue.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module tb_sub16_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        BIN;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] DIFF;
  logic        BOUT;
  logic        OVF;
  logic        ZERO;

  sub16_pipe #(.WIDTH(16), .LO_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .BIN       (BIN),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .DIFF      (DIFF),
    .BOUT      (BOUT),
    .OVF       (OVF),
    .ZERO      (ZERO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        bo;
    logic        ov;
    logic        z;
    int          stp;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int step   = 0;
  bit lat_chk = 0;

  bit          hold_pending = 0;
  logic [15:0] held_d;
  logic        held_bo, held_ov, held_z;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic bi, input int stp);
    exp_t e;
    int   sres;
    int   ures;
    sres  = int'($signed(a)) - int'($signed(b)) - int'(bi);
    ures  = int'(a) - int'(b) - int'(bi);
    e.ov  = (sres > 32767) || (sres < -32768);
    e.bo  = (ures < 0);
    e.d   = 16'(ures);
`ifdef SUB16_SAT_EN
    if (e.ov) e.d = a[15] ? 16'h8000 : 16'h7FFF;
`endif
    e.z   = (e.d == 16'h0000);
    e.stp = stp;
    return e;
  endfunction

  // One clock cycle: drive inputs, check outputs/handshake, update the
  // model with whatever transfers happen at the coming edge.
  task automatic cycle(input logic iv, input logic [15:0] a, input logic [15:0] b,
                       input logic bi, input logic ordy, output logic acc);
    exp_t e;
    in_valid  = iv;
    A         = a;
    B         = b;
    BIN       = bi;
    out_ready = ordy;
    #1;
    if (hold_pending) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_diff",  32'(DIFF),  32'(held_d));
      chk("hold_flags", {29'd0, BOUT, OVF, ZERO}, {29'd0, held_bo, held_ov, held_z});
    end
    chk("in_ready", 32'(in_ready), 32'(!(q.size() == 2 && !ordy)));
    if (q.size() == 0) chk("idle_valid", 32'(out_valid), 32'd0);
    if (out_valid && ordy && q.size() != 0) begin
      e = q.pop_front();
      chk("diff", 32'(DIFF), 32'(e.d));
      chk("bout", 32'(BOUT), 32'(e.bo));
      chk("ovf",  32'(OVF),  32'(e.ov));
      chk("zero", 32'(ZERO), 32'(e.z));
      if (lat_chk) chk("latency", 32'(step - e.stp), 32'd2);
    end
    hold_pending = out_valid && !ordy;
    held_d  = DIFF;
    held_bo = BOUT;
    held_ov = OVF;
    held_z  = ZERO;
    acc = iv && in_ready;
    if (acc) q.push_back(model(a, b, bi, step));
    @(posedge clk);
    @(negedge clk);
    step++;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
  endtask

  logic        acc;
  logic [15:0] ops_a[4];
  logic [15:0] ops_b[4];
  int          idx;
  int          n_acc;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; BIN = 1'b0; out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_diff",  32'(DIFF), 32'd0);
    chk("rst_flags", {29'd0, BOUT, OVF, ZERO}, 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed corners
    cycle(1'b1, 16'h0000, 16'h0001, 1'b0, 1'b1, acc);
    cycle(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, acc);
    cycle(1'b1, 16'h1234, 16'h1233, 1'b1, 1'b1, acc);
    cycle(1'b1, 16'h0100, 16'h0001, 1'b0, 1'b1, acc);
    cycle(1'b1, 16'h7FFF, 16'hFFFF, 1'b0, 1'b1, acc);
    cycle(1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1, acc);
    idle(3);

    // Back-to-back random ops, one per cycle, fixed latency
    lat_chk = 1;
    for (int i = 0; i < 100; i++)
      cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1, acc);
    idle(3);
    lat_chk = 0;

    // Backpressure: 5 stalled cycles while offering 4 ops
    for (int i = 0; i < 4; i++) begin
      ops_a[i] = 16'($urandom);
      ops_b[i] = 16'($urandom);
    end
    idx = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, ops_a[idx], ops_b[idx], 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    n_acc = idx;
    chk("stall_accepted", 32'(n_acc), 32'd2);
    #1;
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    while (idx < 4) begin
      cycle(1'b1, ops_a[idx], ops_b[idx], 1'b0, 1'b1, acc);
      if (acc) idx++;
    end
    idle(3);
    chk("stall_drained", 32'(q.size()), 32'd0);

    // Random handshake mix
    for (int i = 0; i < 200; i++)
      cycle(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
            1'($urandom_range(0, 3) != 0), acc);
    idle(4);
    chk("mix_drained", 32'(q.size()), 32'd0);

    // Reset with two ops in flight
    cycle(1'b1, 16'h4444, 16'h1111, 1'b0, 1'b1, acc);
    cycle(1'b1, 16'h5555, 16'h2222, 1'b0, 1'b1, acc);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_diff",  32'(DIFF), 32'd0);
    q.delete();
    hold_pending = 0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    cycle(1'b1, 16'h0100, 16'h0001, 1'b0, 1'b1, acc);
    idle(3);
    chk("post_rst_drained", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
